memory_aligner: RTL and testbench
=================================

MEMORY_ALIGNER -- requirements
Module: memory_aligner

Interface
REQ-001 SHALL have parameter SIZE, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port memory_enable  input  1  request valid from memory unit; held until memory_ready seen.
REQ-005 SHALL have port memory_operation  input  1  0 = load, 1 = store.
REQ-006 SHALL have port memory_data_size  input  2  0 byte, 1 half, 2 word, 3 invalid.
REQ-007 SHALL have port memory_address  input  SIZE  byte address.
REQ-008 SHALL have port memory_data_out  input  SIZE  store data, right-aligned.
REQ-009 SHALL have port memory_ready  output  1  one-cycle completion pulse to memory unit.
REQ-010 SHALL have port memory_data_in  output  SIZE  load data, right-aligned, upper bytes zero.
REQ-011 SHALL have port ram_enable  output  1  word RAM request valid.
REQ-012 SHALL have port ram_write  output  1  1 = write, 0 = read.
REQ-013 SHALL have port ram_byte_enable  output  4  per-byte lane enables, bit i = bits 8i+7:8i.
REQ-014 SHALL have port ram_address  output  SIZE-2  word address.
REQ-015 SHALL have port ram_write_data  output  SIZE  lane-positioned write data.
REQ-016 SHALL have port ram_read_data  input  SIZE  read word, valid when ram_ready is high.
REQ-017 SHALL have port ram_ready  input  1  RAM accepts/completes the current request this cycle (any wait states).

Function
REQ-018 SHALL implement states IDLE, FIRST, SECOND, DONE.
REQ-019 In IDLE with memory_enable=1, SHALL latch operation, size, address and store data, then enter FIRST (size 0-2) or DONE (size 3).
REQ-020 Byte count n = 1/2/4 for size 0/1/2; offset o = address[1:0]; word w = address[SIZE-1:2]; access is split when o+n > 4.
REQ-021 In FIRST, SHALL drive ram_enable=1, ram_address=w, ram_byte_enable=((1<<n)-1)<<o truncated to 4 bits, and ram_write_data=data<<8o truncated to 32 bits; it SHALL hold all of these until ram_ready=1.
REQ-022 On FIRST with ram_ready=1, SHALL capture ram_read_data as low word, then enter SECOND if split, else DONE.
REQ-023 In SECOND, SHALL drive ram_address=w+1 (mod 2^(SIZE-2), so 0x3FFFFFFF wraps to 0), ram_byte_enable=((1<<n)-1)>>(4-o), and ram_write_data=data>>8(4-o); it SHALL hold these until ram_ready=1, then capture the high word and enter DONE.
REQ-024 In DONE, SHALL assert memory_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-025 memory_data_in SHALL be updated on entry to DONE to ({high,low}>>8o) masked to n bytes; it SHALL be 0 for stores and size 3, and SHALL hold its value until the next DONE.
REQ-026 ram_enable SHALL be 0 in IDLE and DONE; ram_write SHALL equal the latched operation while ram_enable=1, else 0; ram_byte_enable, ram_address and ram_write_data SHALL be 0 while ram_enable=0.
REQ-027 SHALL ignore memory_enable outside IDLE; request inputs changing mid-access SHALL have no effect.
REQ-028 Minimum latency, aligned with zero-wait RAM: request accepted cycle t, RAM access at t+1, memory_ready at t+2; split access: memory_ready at t+3.
REQ-029 SHALL perform no sign extension; sign extension is the memory unit's job.

Reset
REQ-030 While reset=0, SHALL immediately (asynchronously) force state IDLE and memory_ready, memory_data_in, ram_enable, ram_write, ram_byte_enable, ram_address and ram_write_data to 0.
REQ-031 A reset during FIRST or SECOND SHALL abandon the access with no further RAM request and no memory_ready pulse; a partially written split store is acceptable.

Verification
REQ-032 Word load at 0x100, RAM word 0x40 = 0xDEADBEEF, zero wait -> one RAM read at 0x40 with byte enables 0xF; memory_ready at t+2; memory_data_in = 0xDEADBEEF.
REQ-033 Byte store 0xAB at 0x203 -> one RAM write at 0x80 with byte enables 0x8 and write data 0xAB000000; memory_ready at t+2; memory_data_in = 0.
REQ-034 Word load at 0x102, word 0x40 = 0x11223344, word 0x41 = 0x55667788 -> reads at 0x40 (enables 0xC), then 0x41 (enables 0x3); memory_data_in = 0x77881122; memory_ready at t+3.
REQ-035 Half store 0xCAFE at 0xFFFFFFFF -> writes at 0x3FFFFFFF (enables 0x8, data 0xFE000000), then at 0 (enables 0x1, data 0x000000CA).
REQ-036 Aligned read with ram_ready held low for 3 cycles -> RAM outputs stable throughout; memory_ready exactly one cycle after ram_ready; size 3 request -> no ram_enable, memory_ready at t+1.
REQ-037 reset driven low mid-SECOND -> all outputs 0 without waiting for a clock edge; after release, no memory_ready pulse until a new request.

Source files
------------

// File: rtl/memory_aligner.sv
// memory_aligner: turns byte/half/word requests at arbitrary byte addresses
// into one or two word-RAM accesses with per-lane byte enables, and returns
// right-aligned, zero-extended load data.
//
// state  | meaning
// IDLE   | waiting for memory_enable; request fields are latched on accept
// FIRST  | RAM access to word w, held until ram_ready
// SECOND | RAM access to word w+1 for lane-crossing requests, held until ram_ready
// DONE   | one-cycle memory_ready pulse, then back to IDLE
module memory_aligner #(
  parameter int SIZE = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            memory_enable,
  input  logic            memory_operation,
  input  logic [1:0]      memory_data_size,
  input  logic [SIZE-1:0] memory_address,
  input  logic [SIZE-1:0] memory_data_out,
  output logic            memory_ready,
  output logic [SIZE-1:0] memory_data_in,
  output logic            ram_enable,
  output logic            ram_write,
  output logic [3:0]      ram_byte_enable,
  output logic [SIZE-3:0] ram_address,
  output logic [SIZE-1:0] ram_write_data,
  input  logic [SIZE-1:0] ram_read_data,
  input  logic            ram_ready
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t          state;
  logic            op_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic [SIZE-3:0] word_q;
  logic [SIZE-1:0] data_q;
  logic [SIZE-1:0] low_q;

  logic [1:0]        cur_size;
  logic [1:0]        cur_off;
  logic [SIZE-1:0]   cur_data;
  logic [3:0]        n_mask;
  logic [7:0]        be_wide;
  logic [2*SIZE-1:0] wd_wide;
  logic              split;
  logic [SIZE-1:0]   byte_mask;
  logic [SIZE-1:0]   rd_lo;
  logic [SIZE-1:0]   rd_hi;
  logic [SIZE-1:0]   load_val;

  // Lane placement: in IDLE the live request is used so the first RAM
  // access can be registered on the accept edge; afterwards the latched copy.
  always_comb begin
    cur_size = (state == IDLE) ? memory_data_size : size_q;
    cur_off  = (state == IDLE) ? memory_address[1:0] : off_q;
    cur_data = (state == IDLE) ? memory_data_out : data_q;
    case (cur_size)
      2'd0:    n_mask = 4'h1;
      2'd1:    n_mask = 4'h3;
      default: n_mask = 4'hF;
    endcase
    case (cur_size)
      2'd0:    byte_mask = SIZE'(32'h0000_00FF);
      2'd1:    byte_mask = SIZE'(32'h0000_FFFF);
      default: byte_mask = SIZE'(32'hFFFF_FFFF);
    endcase
    // Upper nibble / upper word of the widened shift is the second-word part.
    be_wide  = {4'h0, n_mask} << cur_off;
    wd_wide  = {{SIZE{1'b0}}, cur_data} << {cur_off, 3'b000};
    split    = (be_wide[7:4] != 4'h0);
    rd_lo    = (state == SECOND) ? low_q : ram_read_data;
    rd_hi    = (state == SECOND) ? ram_read_data : '0;
    load_val = op_q ? '0 : (SIZE'({rd_hi, rd_lo} >> {cur_off, 3'b000}) & byte_mask);
  end

  // Sequencer with registered RAM and memory-unit outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op_q            <= 1'b0;
      size_q          <= 2'd0;
      off_q           <= 2'd0;
      word_q          <= '0;
      data_q          <= '0;
      low_q           <= '0;
      memory_ready    <= 1'b0;
      memory_data_in  <= '0;
      ram_enable      <= 1'b0;
      ram_write       <= 1'b0;
      ram_byte_enable <= 4'h0;
      ram_address     <= '0;
      ram_write_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          memory_ready <= 1'b0;
          if (memory_enable) begin
            op_q   <= memory_operation;
            size_q <= memory_data_size;
            off_q  <= memory_address[1:0];
            word_q <= memory_address[SIZE-1:2];
            data_q <= memory_data_out;
            if (memory_data_size == 2'd3) begin
              state          <= DONE;
              memory_ready   <= 1'b1;
              memory_data_in <= '0;
            end else begin
              state           <= FIRST;
              ram_enable      <= 1'b1;
              ram_write       <= memory_operation;
              ram_byte_enable <= be_wide[3:0];
              ram_address     <= memory_address[SIZE-1:2];
              ram_write_data  <= wd_wide[SIZE-1:0];
            end
          end
        end
        FIRST: begin
          if (ram_ready) begin
            low_q <= ram_read_data;
            if (split) begin
              state           <= SECOND;
              ram_byte_enable <= be_wide[7:4];
              ram_address     <= word_q + {{(SIZE-3){1'b0}}, 1'b1};
              ram_write_data  <= wd_wide[2*SIZE-1:SIZE];
            end else begin
              state           <= DONE;
              memory_ready    <= 1'b1;
              memory_data_in  <= load_val;
              ram_enable      <= 1'b0;
              ram_write       <= 1'b0;
              ram_byte_enable <= 4'h0;
              ram_address     <= '0;
              ram_write_data  <= '0;
            end
          end
        end
        SECOND: begin
          if (ram_ready) begin
            state           <= DONE;
            memory_ready    <= 1'b1;
            memory_data_in  <= load_val;
            ram_enable      <= 1'b0;
            ram_write       <= 1'b0;
            ram_byte_enable <= 4'h0;
            ram_address     <= '0;
            ram_write_data  <= '0;
          end
        end
        DONE: begin
          memory_ready <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_aligner.sv
// Directed bench for memory_aligner: word RAM model with programmable wait
// states, a log of every accepted RAM transaction, and hand-computed results.
module tb_memory_aligner;

  logic        clock;
  logic        reset;
  logic        memory_enable;
  logic        memory_operation;
  logic [1:0]  memory_data_size;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic        memory_ready;
  logic [31:0] memory_data_in;
  logic        ram_enable;
  logic        ram_write;
  logic [3:0]  ram_byte_enable;
  logic [29:0] ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [logic [29:0]];
  int          cfg_wait = 0;
  int          wait_cnt = 0;

  logic        log_we   [64];
  logic [29:0] log_addr [64];
  logic [3:0]  log_be   [64];
  logic [31:0] log_wd   [64];
  int          log_cnt = 0;

  memory_aligner #(.SIZE(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .memory_enable    (memory_enable),
    .memory_operation (memory_operation),
    .memory_data_size (memory_data_size),
    .memory_address   (memory_address),
    .memory_data_out  (memory_data_out),
    .memory_ready     (memory_ready),
    .memory_data_in   (memory_data_in),
    .ram_enable       (ram_enable),
    .ram_write        (ram_write),
    .ram_byte_enable  (ram_byte_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data),
    .ram_ready        (ram_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: ready after cfg_wait stalled cycles per access phase.
  always @(negedge clock) begin
    if (ram_enable) begin
      if (wait_cnt >= cfg_wait) begin
        ram_ready = 1'b1;
        wait_cnt  = 0;
      end else begin
        ram_ready = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      ram_ready = 1'b0;
      wait_cnt  = 0;
    end
    ram_read_data = mem.exists(ram_address) ? mem[ram_address] : 32'h0;
  end

  // Record every completed RAM handshake.
  always @(posedge clock) begin
    if (ram_enable && ram_ready && log_cnt < 64) begin
      log_we[log_cnt]   <= ram_write;
      log_addr[log_cnt] <= ram_address;
      log_be[log_cnt]   <= ram_byte_enable;
      log_wd[log_cnt]   <= ram_write_data;
      log_cnt           <= log_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_ram(input string tag, input int idx, input logic we,
                           input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wd);
    check({tag, "_we"},   32'(log_we[idx]),   32'(we));
    check({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
    check({tag, "_be"},   32'(log_be[idx]),   32'(be));
    check({tag, "_wd"},   log_wd[idx],        wd);
  endtask

  task automatic do_access(input string tag, input logic op, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input int exp_lat, input logic [31:0] exp_din,
                           input int exp_n, output int base);
    int lat;
    @(negedge clock);
    base             = log_cnt;
    memory_enable    = 1'b1;
    memory_operation = op;
    memory_data_size = sz;
    memory_address   = addr;
    memory_data_out  = wdat;
    @(posedge clock);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (memory_ready) begin
        lat = k;
        break;
      end
    end
    memory_enable = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data_in"}, memory_data_in, exp_din);
    check({tag, "_ram_count"}, 32'(log_cnt - base), 32'(exp_n));
    check({tag, "_ram_idle"}, 32'({ram_enable, ram_write, ram_byte_enable,
                                   |ram_address, |ram_write_data}), 32'h0);
    @(negedge clock);
    check({tag, "_ready_pulse"}, 32'(memory_ready), 32'h0);
    check({tag, "_data_hold"}, memory_data_in, exp_din);
  endtask

  initial begin
    int  b;
    logic saw_ready;
    logic saw_en;
    reset            = 1'b0;
    memory_enable    = 1'b0;
    memory_operation = 1'b0;
    memory_data_size = 2'd0;
    memory_address   = 32'h0;
    memory_data_out  = 32'h0;
    ram_ready        = 1'b0;
    ram_read_data    = 32'h0;

    #23;
    check("reset_ready", 32'(memory_ready), 32'h0);
    check("reset_ram", 32'({ram_enable, ram_write, ram_byte_enable,
                            |ram_address, |ram_write_data}), 32'h0);
    check("reset_data_in", memory_data_in, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Aligned word load.
    mem[30'h40] = 32'hDEADBEEF;
    do_access("word_load", 1'b0, 2'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1, b);
    check_ram("word_load_r0", b, 1'b0, 30'h40, 4'hF, 32'h0);

    // Byte store into top lane.
    do_access("byte_store", 1'b1, 2'd0, 32'h203, 32'h000000AB, 2, 32'h0, 1, b);
    check_ram("byte_store_w0", b, 1'b1, 30'h80, 4'h8, 32'hAB000000);

    // Misaligned word load crossing a word boundary.
    mem[30'h40] = 32'h11223344;
    mem[30'h41] = 32'h55667788;
    do_access("split_load", 1'b0, 2'd2, 32'h102, 32'h0, 3, 32'h77881122, 2, b);
    check_ram("split_load_r0", b,     1'b0, 30'h40, 4'hC, 32'h0);
    check_ram("split_load_r1", b + 1, 1'b0, 30'h41, 4'h3, 32'h0);

    // Half store at the very top of the address space: word address wraps.
    do_access("wrap_store", 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0000CAFE, 3, 32'h0, 2, b);
    check_ram("wrap_store_w0", b,     1'b1, 30'h3FFFFFFF, 4'h8, 32'hFE000000);
    check_ram("wrap_store_w1", b + 1, 1'b1, 30'h0,        4'h1, 32'h000000CA);

    // Byte load from lane 1, zero-extended.
    do_access("byte_load", 1'b0, 2'd0, 32'h101, 32'h0, 2, 32'h00000033, 1, b);
    check_ram("byte_load_r0", b, 1'b0, 30'h40, 4'h2, 32'h0);

    // Half load crossing the boundary from lane 3.
    do_access("half_split", 1'b0, 2'd1, 32'h103, 32'h0, 3, 32'h00008811, 2, b);
    check_ram("half_split_r0", b,     1'b0, 30'h40, 4'h8, 32'h0);
    check_ram("half_split_r1", b + 1, 1'b0, 30'h41, 4'h1, 32'h0);

    // Invalid size: no RAM traffic, ready at t+1, data cleared.
    do_access("bad_size", 1'b0, 2'd3, 32'h100, 32'h0, 1, 32'h0, 0, b);

    // Wait states: outputs held steady while ram_ready is low.
    cfg_wait = 3;
    mem[30'h50] = 32'hCAFEF00D;
    @(negedge clock);
    memory_enable    = 1'b1;
    memory_operation = 1'b0;
    memory_data_size = 2'd2;
    memory_address   = 32'h140;
    @(posedge clock);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("wait_ctrl", 32'({ram_enable, ram_write, ram_byte_enable}), 32'h2F);
      check("wait_addr", 32'(ram_address), 32'h50);
      check("wait_wd", ram_write_data, 32'h0);
      check("wait_no_ready", 32'(memory_ready), 32'h0);
    end
    @(negedge clock);
    check("wait_handshake_no_ready", 32'(memory_ready), 32'h0);
    @(negedge clock);
    memory_enable = 1'b0;
    check("wait_ready", 32'(memory_ready), 32'h1);
    check("wait_data_in", memory_data_in, 32'hCAFEF00D);
    @(negedge clock);
    check("wait_ready_pulse", 32'(memory_ready), 32'h0);

    // Reset while the second word access is outstanding.
    cfg_wait = 2;
    @(negedge clock);
    memory_enable    = 1'b1;
    memory_operation = 1'b0;
    memory_data_size = 2'd2;
    memory_address   = 32'h102;
    @(posedge clock);
    repeat (3) @(negedge clock);
    @(negedge clock);
    check("rst_in_second_addr", 32'(ram_address), 32'h41);
    memory_enable = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_async_ram", 32'({ram_enable, ram_write, ram_byte_enable,
                                |ram_address, |ram_write_data}), 32'h0);
    check("rst_async_data_in", memory_data_in, 32'h0);
    check("rst_async_ready", 32'(memory_ready), 32'h0);
    repeat (2) @(negedge clock);
    reset    = 1'b1;
    cfg_wait = 0;
    saw_ready = 1'b0;
    saw_en    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      saw_ready = saw_ready | memory_ready;
      saw_en    = saw_en | ram_enable;
    end
    check("rst_no_ready_after", 32'(saw_ready), 32'h0);
    check("rst_no_ram_after", 32'(saw_en), 32'h0);

    // Normal operation resumes after reset.
    do_access("post_rst", 1'b0, 2'd1, 32'h102, 32'h0, 2, 32'h00001122, 1, b);
    check_ram("post_rst_r0", b, 1'b0, 30'h40, 4'hC, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
